// File: rtl/instr_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : instr_mem_ctrl
// Description : Sequencer and port arbiter for the single-port instruction
//               BRAM. Owns the port for the program loader after reset, then
//               hands it to the fetch stage (1 read/cycle, 1-cycle latency)
//               once the loader's last word is written.
//               Optional macro IMEM_BOUND_CHECK_EN: fetches at or beyond the
//               loaded word count return NOP_WORD and pulse fetch_oob.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_mem_ctrl #(
   parameter int          ADDR_WIDTH = 5,
   parameter logic [31:0] NOP_WORD   = 32'h0000_0013
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  reload,
   input  logic                  ld_valid,
   input  logic [31:0]           ld_data,
   input  logic                  ld_last,
   output logic                  ld_ready,
   input  logic                  fetch_req,
   input  logic [31:0]           fetch_addr,
   output logic                  fetch_ready,
   output logic                  fetch_valid,
   output logic [31:0]           fetch_data,
   output logic                  fetch_oob,
   output logic                  boot_done,
   output logic                  load_ovf,
   output logic [ADDR_WIDTH:0]   word_count,
   output logic                  mem_we,
   output logic                  mem_en,
   output logic [31:0]           mem_addr,
   output logic [31:0]           mem_din,
   input  logic [31:0]           mem_dout
);

   localparam int DEPTH = 2 ** ADDR_WIDTH;
   localparam logic [ADDR_WIDTH:0] DEPTH_CNT = (ADDR_WIDTH + 1)'(DEPTH);

   typedef enum logic [1:0] {
      S_LOAD = 2'd0,
      S_RUN  = 2'd1,
      S_OVF  = 2'd2
   } state_t;

   state_t                state, state_nx;
   logic [ADDR_WIDTH:0]   count_nx;
   logic [ADDR_WIDTH:0]   count_inc;
   logic                  ld_acc;
   logic                  fetch_acc;
   logic [ADDR_WIDTH-1:0] fetch_idx;
   logic [ADDR_WIDTH-1:0] index;
   logic [31:0]           rd_word;
   logic [31:0]           data_hold;

   // Handshakes, port arbitration and the combinational BRAM interface
   always_comb begin
      ld_ready    = (state == S_LOAD) & ~reload;
      fetch_ready = (state == S_RUN) & ~reload;
      ld_acc      = ld_valid & ld_ready;
      fetch_acc   = fetch_req & fetch_ready;
      fetch_idx   = fetch_addr[ADDR_WIDTH+1:2];
      index       = ld_acc ? word_count[ADDR_WIDTH-1:0] : fetch_idx;
      mem_en      = ld_acc | fetch_acc;
      mem_we      = ld_acc;
      mem_din     = ld_data;
      mem_addr    = {{(32-ADDR_WIDTH-2){1'b0}}, index, 2'b00};
      boot_done   = (state == S_RUN);
      load_ovf    = (state == S_OVF);
   end

   // Next state and word count; reload wins over any request
   always_comb begin
      state_nx  = state;
      count_nx  = word_count;
      count_inc = word_count + 1'b1;
      if (reload) begin
         state_nx = S_LOAD;
         count_nx = '0;
      end else begin
         case (state)
            S_LOAD: begin
               if (ld_acc) begin
                  count_nx = count_inc;
                  if (ld_last)
                     state_nx = S_RUN;
                  else if (count_inc == DEPTH_CNT)
                     state_nx = S_OVF;
               end
            end
            S_RUN:   state_nx = S_RUN;
            S_OVF:   state_nx = S_OVF;
            default: state_nx = S_LOAD;
         endcase
      end
   end

   // State, word count and read-valid pipeline registers
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state       <= S_LOAD;
         word_count  <= '0;
         fetch_valid <= 1'b0;
      end else begin
         state       <= state_nx;
         word_count  <= count_nx;
         fetch_valid <= fetch_acc;
      end
   end

`ifdef IMEM_BOUND_CHECK_EN
   logic oob_q;
   logic unused_addr_bits;

   assign unused_addr_bits = ^{fetch_addr[31:ADDR_WIDTH+2], fetch_addr[1:0]};

   // Remember whether the accepted fetch lies beyond the loaded program
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)
         oob_q <= 1'b0;
      else
         oob_q <= fetch_acc & ({1'b0, fetch_idx} >= word_count);
   end

   assign rd_word   = oob_q ? NOP_WORD : mem_dout;
   assign fetch_oob = oob_q;
`else
   logic unused_addr_bits;

   assign unused_addr_bits = ^{fetch_addr[31:ADDR_WIDTH+2], fetch_addr[1:0], NOP_WORD};
   assign rd_word   = mem_dout;
   assign fetch_oob = 1'b0;
`endif

   // Keep the last delivered word so fetch_data holds between reads
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)
         data_hold <= '0;
      else if (fetch_valid)
         data_hold <= rd_word;
   end

   assign fetch_data = fetch_valid ? rd_word : data_hold;

endmodule
`default_nettype wire

// File: tb/tb_instr_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_mem_ctrl
// Description : Directed, table-driven bench for instr_mem_ctrl with a
//               behavioural single-port BRAM model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_mem_ctrl;

   logic        clk = 1'b0;
   logic        rstn;
   logic        reload, ld_valid, ld_last, fetch_req;
   logic [31:0] ld_data, fetch_addr;
   logic        ld_ready, fetch_ready, fetch_valid, fetch_oob;
   logic        boot_done, load_ovf, mem_we, mem_en;
   logic [31:0] fetch_data, mem_addr, mem_din, mem_dout;
   logic [5:0]  word_count;

   logic [31:0] bram [0:31];

   int n_vec = 0;
   int n_mis = 0;

`ifdef IMEM_BOUND_CHECK_EN
   localparam logic [31:0] OOB_FD  = 32'h0000_0013;
   localparam logic        OOB_FLG = 1'b1;
`else
   localparam logic [31:0] OOB_FD  = 32'hC0DE_0004;
   localparam logic        OOB_FLG = 1'b0;
`endif

   instr_mem_ctrl #(.ADDR_WIDTH(5), .NOP_WORD(32'h0000_0013)) dut (
      .clk(clk), .rstn(rstn), .reload(reload),
      .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last), .ld_ready(ld_ready),
      .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_ready(fetch_ready),
      .fetch_valid(fetch_valid), .fetch_data(fetch_data), .fetch_oob(fetch_oob),
      .boot_done(boot_done), .load_ovf(load_ovf), .word_count(word_count),
      .mem_we(mem_we), .mem_en(mem_en), .mem_addr(mem_addr), .mem_din(mem_din),
      .mem_dout(mem_dout)
   );

   always #5 clk = ~clk;

   // Behavioural single-port BRAM, read data one cycle after an enabled read
   always @(posedge clk) begin
      if (mem_en) begin
         if (mem_we) bram[mem_addr[6:2]] <= mem_din;
         else        mem_dout <= bram[mem_addr[6:2]];
      end
   end

   typedef struct {
      logic rl, lv; logic [31:0] ld; logic ll, fr; logic [31:0] fa;
      logic e_lr, e_frd, e_en, e_we; logic [31:0] e_ad, e_di;
      logic e_fv, cd; logic [31:0] e_fd; logic e_oob, e_bd, e_ov; logic [5:0] e_wc;
   } vec_t;

   vec_t tbl [0:14];

   function automatic vec_t mk(
      logic rl, logic lv, logic [31:0] ld, logic ll, logic fr, logic [31:0] fa,
      logic lr, logic frd, logic en, logic we, logic [31:0] ad, logic [31:0] di,
      logic fv, logic cd, logic [31:0] fd, logic oob, logic bd, logic ov, logic [5:0] wc);
      vec_t v;
      v.rl = rl; v.lv = lv; v.ld = ld; v.ll = ll; v.fr = fr; v.fa = fa;
      v.e_lr = lr; v.e_frd = frd; v.e_en = en; v.e_we = we; v.e_ad = ad; v.e_di = di;
      v.e_fv = fv; v.cd = cd; v.e_fd = fd; v.e_oob = oob; v.e_bd = bd; v.e_ov = ov;
      v.e_wc = wc;
      return v;
   endfunction

   task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_mis++;
         $display("FAIL %s[%0d] got %h want %h at %0t", nm, idx, act, exp, $time);
      end
   endtask

   // One cycle: drive at the falling edge, sample shortly before the rising edge
   task automatic cyc(input logic rl, input logic lv, input logic [31:0] ld,
                      input logic ll, input logic fr, input logic [31:0] fa);
      @(negedge clk);
      reload = rl; ld_valid = lv; ld_data = ld; ld_last = ll;
      fetch_req = fr; fetch_addr = fa;
      #3;
   endtask

   initial begin
      rstn = 1'b0;
      reload = 0; ld_valid = 0; ld_data = 0; ld_last = 0; fetch_req = 0; fetch_addr = 0;
      repeat (2) @(negedge clk);
      rstn = 1'b1;
      #3;
      chk("rst_ld_ready", 0, 32'(ld_ready), 32'd1);
      chk("rst_boot", 0, 32'(boot_done), 32'd0);
      chk("rst_ovf", 0, 32'(load_ovf), 32'd0);
      chk("rst_wc", 0, 32'(word_count), 32'd0);
      chk("rst_fv", 0, 32'(fetch_valid), 32'd0);
      chk("rst_oob", 0, 32'(fetch_oob), 32'd0);

      // 32 words without ld_last drive the controller into overflow
      for (int i = 0; i < 32; i++) begin
         cyc(0, 1, 32'hC0DE_0000 + 32'(i), 0, 0, 0);
         chk("ovf_ld_ready", i, 32'(ld_ready), 32'd1);
         chk("ovf_we", i, 32'({mem_en, mem_we}), 32'd3);
         chk("ovf_addr", i, mem_addr, 32'(i * 4));
         chk("ovf_wc", i, 32'(word_count), 32'(i));
      end
      cyc(0, 1, 32'hDEAD_BEEF, 0, 1, 0);
      chk("ovf_flag", 0, 32'(load_ovf), 32'd1);
      chk("ovf_ld_ready", 32, 32'(ld_ready), 32'd0);
      chk("ovf_fetch_ready", 0, 32'(fetch_ready), 32'd0);
      chk("ovf_33rd_en", 0, 32'(mem_en), 32'd0);
      chk("ovf_wc", 32, 32'(word_count), 32'd32);
      chk("ovf_boot", 0, 32'(boot_done), 32'd0);
      cyc(0, 0, 0, 0, 0, 0);
      chk("ovf_sticky", 0, 32'(load_ovf), 32'd1);
      chk("ovf_wc_hold", 0, 32'(word_count), 32'd32);

      // Reload out of overflow, then 31 words plus a 32nd carrying ld_last
      cyc(1, 1, 32'hDEAD_BEEF, 0, 0, 0);
      chk("rl_ld_ready", 0, 32'(ld_ready), 32'd0);
      chk("rl_en", 0, 32'(mem_en), 32'd0);
      for (int i = 0; i < 32; i++) begin
         cyc(0, 1, 32'hC0DE_0000 + 32'(i), (i == 31), 0, 0);
         chk("full_en", i, 32'(mem_en), 32'd1);
         chk("full_wc", i, 32'(word_count), 32'(i));
         chk("full_ovf", i, 32'(load_ovf), 32'd0);
      end
      cyc(0, 0, 0, 0, 0, 0);
      chk("full_boot", 0, 32'(boot_done), 32'd1);
      chk("full_ovf", 32, 32'(load_ovf), 32'd0);
      chk("full_wc", 32, 32'(word_count), 32'd32);
      chk("full_fetch_ready", 0, 32'(fetch_ready), 32'd1);
      cyc(0, 0, 0, 0, 1, 32'h7C);
      chk("full_rd_addr", 0, mem_addr, 32'h7C);
      cyc(0, 0, 0, 0, 0, 0);
      chk("full_rd_fv", 0, 32'(fetch_valid), 32'd1);
      chk("full_rd_data", 0, fetch_data, 32'hC0DE_001F);

      // Asynchronous reset mid-fetch clears state without waiting for a clock
      cyc(0, 0, 0, 0, 1, 32'h8);
      @(negedge clk);
      fetch_req = 0;
      #1;
      chk("arst_pre_fv", 0, 32'(fetch_valid), 32'd1);
      rstn = 1'b0;
      #1;
      chk("arst_fv", 0, 32'(fetch_valid), 32'd0);
      chk("arst_boot", 0, 32'(boot_done), 32'd0);
      chk("arst_wc", 0, 32'(word_count), 32'd0);
      @(negedge clk);
      rstn = 1'b1;

      //              rl lv ld          ll fr fa            lr frd en we ad     di        fv cd fd            oob      bd ov wc
      tbl[0]  = mk(0, 0, 0,           0, 0, 0,          1, 0, 0, 0, 0,     0,        0, 0, 0,            0,       0, 0, 0);
      tbl[1]  = mk(0, 1, 32'h11,      0, 0, 0,          1, 0, 1, 1, 32'h0, 32'h11,   0, 0, 0,            0,       0, 0, 0);
      tbl[2]  = mk(0, 1, 32'h22,      0, 0, 0,          1, 0, 1, 1, 32'h4, 32'h22,   0, 0, 0,            0,       0, 0, 1);
      tbl[3]  = mk(0, 1, 32'h33,      1, 0, 0,          1, 0, 1, 1, 32'h8, 32'h33,   0, 0, 0,            0,       0, 0, 2);
      tbl[4]  = mk(0, 0, 0,           0, 1, 32'h4,      0, 1, 1, 0, 32'h4, 0,        0, 0, 0,            0,       1, 0, 3);
      tbl[5]  = mk(0, 0, 0,           0, 1, 32'h8,      0, 1, 1, 0, 32'h8, 0,        1, 1, 32'h22,       0,       1, 0, 3);
      tbl[6]  = mk(0, 0, 0,           0, 1, 32'h0,      0, 1, 1, 0, 32'h0, 0,        1, 1, 32'h33,       0,       1, 0, 3);
      tbl[7]  = mk(0, 0, 0,           0, 0, 0,          0, 1, 0, 0, 0,     0,        1, 1, 32'h11,       0,       1, 0, 3);
      tbl[8]  = mk(0, 0, 0,           0, 0, 0,          0, 1, 0, 0, 0,     0,        0, 1, 32'h11,       0,       1, 0, 3);
      tbl[9]  = mk(0, 0, 0,           0, 1, 32'h10,     0, 1, 1, 0, 32'h10, 0,       0, 1, 32'h11,       0,       1, 0, 3);
      tbl[10] = mk(0, 1, 32'h99,      0, 0, 0,          0, 1, 0, 0, 0,     0,        1, 1, OOB_FD,       OOB_FLG, 1, 0, 3);
      tbl[11] = mk(0, 0, 0,           0, 1, 32'h1007,   0, 1, 1, 0, 32'h4, 0,        0, 1, OOB_FD,       0,       1, 0, 3);
      tbl[12] = mk(1, 0, 0,           0, 1, 32'h4,      0, 0, 0, 0, 0,     0,        1, 1, 32'h22,       0,       1, 0, 3);
      tbl[13] = mk(1, 1, 32'h55,      0, 0, 0,          0, 0, 0, 0, 0,     0,        0, 1, 32'h22,       0,       0, 0, 0);
      tbl[14] = mk(0, 0, 0,           0, 0, 0,          1, 0, 0, 0, 0,     0,        0, 1, 32'h22,       0,       0, 0, 0);

      for (int i = 0; i < 15; i++) begin
         cyc(tbl[i].rl, tbl[i].lv, tbl[i].ld, tbl[i].ll, tbl[i].fr, tbl[i].fa);
         chk("ld_ready", i, 32'(ld_ready), 32'(tbl[i].e_lr));
         chk("fetch_ready", i, 32'(fetch_ready), 32'(tbl[i].e_frd));
         chk("mem_en", i, 32'(mem_en), 32'(tbl[i].e_en));
         chk("mem_we", i, 32'(mem_we), 32'(tbl[i].e_we));
         if (tbl[i].e_en) chk("mem_addr", i, mem_addr, tbl[i].e_ad);
         if (tbl[i].e_we) chk("mem_din", i, mem_din, tbl[i].e_di);
         chk("fetch_valid", i, 32'(fetch_valid), 32'(tbl[i].e_fv));
         if (tbl[i].cd) chk("fetch_data", i, fetch_data, tbl[i].e_fd);
         chk("fetch_oob", i, 32'(fetch_oob), 32'(tbl[i].e_oob));
         chk("boot_done", i, 32'(boot_done), 32'(tbl[i].e_bd));
         chk("load_ovf", i, 32'(load_ovf), 32'(tbl[i].e_ov));
         chk("word_count", i, 32'(word_count), 32'(tbl[i].e_wc));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/instr_mem_ctrl.md
Name: instr_mem_ctrl

Overview:
Sequencer and port arbiter for the single-port instruction BRAM wrapper. After reset it owns the memory for the program loader, which streams words in over a valid/ready handshake. On the loader's last word it hands the port to the fetch stage and serves pipelined reads, one per cycle, with 1-cycle latency. Supports reload and overflow detection, and sits between the UART loader, the IF stage and the instruction memory.

Parameters:
ADDR_WIDTH, 5, word-index bits; depth = 2**ADDR_WIDTH words (32)
NOP_WORD, 32'h00000013, word returned on out-of-bound fetch (optional feature)

Ports:
clk  in  1  system clock
rstn  in  1  asynchronous active-low reset
reload  in  1  return to load mode, clear count
ld_valid  in  1  loader word valid
ld_data  in  32  loader word
ld_last  in  1  qualifies final word of program
ld_ready  out  1  controller accepts loader word
fetch_req  in  1  fetch request
fetch_addr  in  32  fetch byte address
fetch_ready  out  1  controller accepts fetch request
fetch_valid  out  1  fetch_data valid
fetch_data  out  32  fetched instruction
fetch_oob  out  1  pulse: fetch beyond loaded program (optional feature)
boot_done  out  1  program loaded, fetch enabled
load_ovf  out  1  loader exceeded depth without ld_last
word_count  out  ADDR_WIDTH+1  words loaded
mem_we  out  1  BRAM write enable
mem_en  out  1  BRAM enable
mem_addr  out  32  BRAM byte address
mem_din  out  32  BRAM write data
mem_dout  in  32  BRAM read data, valid 1 cycle after enabled read

Behaviour:
- States: S_LOAD, S_RUN, S_OVF. Reset -> S_LOAD, word_count=0, fetch_valid=0, fetch_oob=0, boot_done=0, load_ovf=0.
- boot_done = (state==S_RUN); load_ovf = (state==S_OVF).
- mem_addr is always {0, index[ADDR_WIDTH-1:0], 2'b00}. mem_en/mem_we/mem_din/mem_addr are combinational.
- ld_ready = (state==S_LOAD) & ~reload. It is therefore 1 from the first cycle after reset release.
- Load accept (ld_valid & ld_ready):
  - mem_en=1, mem_we=1, index=word_count[ADDR_WIDTH-1:0], mem_din=ld_data; word_count++.
  - ld_last=1 -> S_RUN next cycle.
  - Else if the accepted word makes word_count==DEPTH -> S_OVF.
  - A word accepted with ld_last at word_count==DEPTH-1 -> S_RUN, not S_OVF.
- S_OVF: ld_ready=0, fetch_ready=0. Exit only via reload or reset.
- fetch_ready = (state==S_RUN) & ~reload.
- Fetch accept (fetch_req & fetch_ready):
  - mem_en=1, mem_we=0, index=fetch_addr[ADDR_WIDTH+1:2]; fetch_addr[1:0] and upper bits are ignored.
  - Next cycle fetch_valid=1, fetch_data=mem_dout. Back-to-back requests produce back-to-back results.
- No request accepted -> mem_en=0, fetch_valid=0 next cycle; fetch_data holds its last value.
- reload=1, any state:
  - Next state S_LOAD, word_count=0.
  - Suppresses the fetch_valid that would follow in the next cycle.
  - Takes priority over a simultaneous ld_valid or fetch_req; neither is accepted.
- ld_valid in S_RUN is ignored (ld_ready=0). fetch_req outside S_RUN is ignored.
- rstn assertion mid-load or mid-fetch: immediate return to reset values; BRAM contents are not cleared.

Optional Feature:
IMEM_BOUND_CHECK_EN
- Defined: an accepted fetch whose word index >= word_count returns fetch_data=NOP_WORD with fetch_valid=1, plus a 1-cycle fetch_oob pulse aligned with fetch_valid.
- Not defined: raw mem_dout is always returned; fetch_oob is tied 0.

Test Plan:
- Reset, load 3 words 0x11,0x22,0x33 with ld_last on the third -> mem writes at byte addrs 0x0,0x4,0x8; word_count=3; boot_done=1 on the following cycle; ld_ready=0.
- After load, fetch_req at addrs 0x4,0x8,0x0 on consecutive cycles -> fetch_valid high for 3 cycles, delayed 1 cycle, data 0x22,0x33,0x11.
- Load 32 words without ld_last -> load_ovf=1 after the 32nd accept; the 33rd ld_valid is not accepted; fetch_ready=0.
- Load 31 words then a 32nd with ld_last -> boot_done=1, load_ovf=0, word_count=32.
- In S_RUN, assert reload in the same cycle as fetch_req -> no fetch_valid next cycle; state S_LOAD, word_count=0, ld_ready=1.
- With IMEM_BOUND_CHECK_EN, word_count=3, fetch addr 0x10 -> fetch_data=0x00000013, fetch_oob=1 for one cycle. Without the macro -> fetch_data equals raw BRAM content, fetch_oob=0.
